interrupt_sequencer: RTL

Drives the 65C02 interrupt and reset entry sequences: pushes PCH, PCL and the processor status onto the stack, sets I, fetches the vector and hands the new PC to the program counter logic. It consumes the status register's output byte (`db_out`) and its I/D bits. It produces the `psr_i_set` request that the status register logic applies. It sits between the status register, the stack pointer, the bus interface and instruction decode.

---
 rtl/interrupt_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
//
// Runs the 65C02 reset, BRK, IRQ and NMI entry sequences. For BRK/IRQ/NMI it
// pushes PCH, PCL and P onto page 01, fetches the 16-bit vector, then asks the
// status register to set I (and clear D) and the PC logic to load the vector.
// The reset sequence replaces the three pushes with three dummy stack reads.
//
// Ports
//   phi2        in   clock, all state changes on the rising edge
//   resb        in   synchronous active-low reset
//   irqb        in   IRQ, level-sensitive, active-low
//   nmib        in   NMI, falling-edge-sensitive, active-low
//   brk_req     in   one-cycle BRK pulse from decode
//   instr_done  in   one-cycle instruction-boundary pulse
//   p_in[7:0]   in   status register byte (bit 2 = I)
//   pc_in[15:0] in   return address (PC+2 for BRK)
//   sp_in[7:0]  in   current stack pointer
//   data_in[7:0] in  bus read data
//   mem_ready   in   bus cycle completes when high
//   addr[15:0]  out  bus address
//   data_out[7:0] out bus write data
//   we          out  write enable
//   sp_dec      out  decrement SP (completing stack cycle)
//   psr_i_set   out  set I / clear D
//   pc_load     out  load pc_vector into PC
//   pc_vector[15:0] out fetched vector
//   busy        out  sequence in progress (low only in IDLE)
// ---------------------------------------------------------------------------
module interrupt_sequencer (
  input  logic        phi2,
  input  logic        resb,
  input  logic        irqb,
  input  logic        nmib,
  input  logic        brk_req,
  input  logic        instr_done,
  input  logic [7:0]  p_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  input  logic        mem_ready,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        we,
  output logic        sp_dec,
  output logic        psr_i_set,
  output logic        pc_load,
  output logic [15:0] pc_vector,
  output logic        busy
);

  localparam logic [3:0] RST      = 4'd0;
  localparam logic [3:0] R1       = 4'd1;
  localparam logic [3:0] R2       = 4'd2;
  localparam logic [3:0] R3       = 4'd3;
  localparam logic [3:0] IDLE     = 4'd4;
  localparam logic [3:0] PUSH_PCH = 4'd5;
  localparam logic [3:0] PUSH_PCL = 4'd6;
  localparam logic [3:0] PUSH_P   = 4'd7;
  localparam logic [3:0] VEC_LO   = 4'd8;
  localparam logic [3:0] VEC_HI   = 4'd9;
  localparam logic [3:0] DONE     = 4'd10;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic        nmib_q;
  logic        nmi_pend;
  logic [15:0] pc_snap;
  logic [7:0]  p_snap;
  logic [15:0] vec_snap;
  logic [7:0]  vec_lo;

  logic        take_brk;
  logic        take_nmi;
  logic        take_irq;
  logic        trigger;
  logic [7:0]  p_push;
  logic        in_stack;
  logic        in_push;

  // BRK outranks everything; NMI outranks IRQ; both only at a boundary.
  always_comb begin
    take_brk = (state == IDLE) && brk_req;
    take_nmi = (state == IDLE) && !brk_req && instr_done && nmi_pend;
    take_irq = (state == IDLE) && !brk_req && instr_done && !nmi_pend &&
               !irqb && !p_in[2];
    trigger  = take_brk || take_nmi || take_irq;
    // Bit 5 always reads as 1 on the stack; B marks a software break.
    p_push    = p_in | 8'h20;
    p_push[4] = take_brk;
  end

  always_comb begin
    next_state = state;
    case (state)
      RST:      next_state = R1;
      R1:       if (mem_ready) next_state = R2;
      R2:       if (mem_ready) next_state = R3;
      R3:       if (mem_ready) next_state = VEC_LO;
      IDLE:     if (trigger)   next_state = PUSH_PCH;
      PUSH_PCH: if (mem_ready) next_state = PUSH_PCL;
      PUSH_PCL: if (mem_ready) next_state = PUSH_P;
      PUSH_P:   if (mem_ready) next_state = VEC_LO;
      VEC_LO:   if (mem_ready) next_state = VEC_HI;
      VEC_HI:   if (mem_ready) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = RST;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (!resb) begin
      state     <= RST;
      nmib_q    <= 1'b1;
      nmi_pend  <= 1'b0;
      pc_snap   <= 16'h0000;
      p_snap    <= 8'h00;
      vec_snap  <= 16'h0000;
      vec_lo    <= 8'h00;
      pc_vector <= 16'h0000;
    end else begin
      state  <= next_state;
      nmib_q <= nmib;
      // A fresh falling edge wins over the clear so it is never lost.
      if ((state != RST) && nmib_q && !nmib)
        nmi_pend <= 1'b1;
      else if (take_nmi)
        nmi_pend <= 1'b0;
      if (state == RST)
        vec_snap <= VEC_RST;
      if (trigger) begin
        pc_snap  <= pc_in;
        p_snap   <= p_push;
        vec_snap <= take_nmi ? VEC_NMI : VEC_IRQ;
      end
      if ((state == VEC_LO) && mem_ready)
        vec_lo <= data_in;
      if ((state == VEC_HI) && mem_ready)
        pc_vector <= {data_in, vec_lo};
    end
  end

  // Bus outputs decode straight from the state register and snapshots, so
  // they hold steady for the whole bus state regardless of stalls.
  always_comb begin
    in_stack  = (state == R1) || (state == R2) || (state == R3) ||
                (state == PUSH_PCH) || (state == PUSH_PCL) || (state == PUSH_P);
    in_push   = (state == PUSH_PCH) || (state == PUSH_PCL) || (state == PUSH_P);
    addr      = 16'h0000;
    data_out  = 8'h00;
    if (in_stack)
      addr = {8'h01, sp_in};
    else if (state == VEC_LO)
      addr = vec_snap;
    else if (state == VEC_HI)
      addr = vec_snap + 16'd1;
    case (state)
      PUSH_PCH: data_out = pc_snap[15:8];
      PUSH_PCL: data_out = pc_snap[7:0];
      PUSH_P:   data_out = p_snap;
      default:  data_out = 8'h00;
    endcase
    // A reset arriving mid-push must not let the pending write or SP
    // decrement land, so both are qualified with resb.
    we        = in_push && resb;
    sp_dec    = in_stack && mem_ready && resb;
    pc_load   = (state == DONE);
    psr_i_set = (state == DONE);
    busy      = (state != IDLE);
  end

endmodule
